// File: rtl/csr_commit_ctrl.sv
// -----------------------------------------------------------------------------
// csr_commit_ctrl
//
// Commit-side sequencer for CSR instructions. When the scoreboard head is a
// CSR op, the op, address, operand and destination register are captured and
// an access is issued to the CSR file. The block then waits for a possibly
// multi-cycle response, or gives up after TIMEOUT_CYCLES request cycles. It
// retires the instruction with either a register write-back or an
// illegal-instruction exception, and pulses csr_commit_o to free the CSR
// buffer entry.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   flush_i              pipeline flush (only honoured in IDLE)
//   commit_valid_i       head is a CSR op ready to retire
//   commit_op_i          0=write 1=set 2=clear 3=read
//   commit_wdata_i       operand from the CSR buffer
//   commit_rd_i          destination register
//   csr_addr_i           buffered CSR address
//   csr_req_o            access request (high for the whole REQ state)
//   csr_op_o/addr_o/wdata_o  captured access fields (wdata is 0 for read)
//   csr_rvalid_i         response valid
//   csr_rdata_i          old CSR value
//   csr_exception_i      access illegal, qualified by csr_rvalid_i
//   csr_commit_o         frees the CSR buffer entry (one-cycle pulse)
//   commit_ack_o         instruction retired (one-cycle pulse)
//   wb_valid_o/rd_o/data_o   register write-back
//   ex_valid_o/cause_o   exception (cause 2 = illegal instruction)
//   busy_o               block not in IDLE
//
// All outputs are registered. The next value of every output is computed from
// the next state, so the outputs line up with the registered state.
// -----------------------------------------------------------------------------
module csr_commit_ctrl #(
    parameter int unsigned XLEN           = 32'd64,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  logic [1:0]      commit_op_i,
    input  logic [XLEN-1:0] commit_wdata_i,
    input  logic [4:0]      commit_rd_i,
    input  logic [11:0]     csr_addr_i,
    output logic            csr_req_o,
    output logic [1:0]      csr_op_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic            csr_rvalid_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_exception_i,
    output logic            csr_commit_o,
    output logic            commit_ack_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            ex_valid_o,
    output logic [3:0]      ex_cause_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_READ       = 2'd3;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    // Last counter value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT_CYCLES - 32'd1);

    state_e            state_r, state_s;
    logic [7:0]        cnt_r, cnt_s;
    logic [1:0]        op_r, op_s;
    logic [11:0]       addr_r, addr_s;
    logic [XLEN-1:0]   wdata_r, wdata_s;
    logic [4:0]        rd_r, rd_s;
    logic              req_r, req_s;
    logic              ack_r, ack_s;
    logic              wb_valid_r, wb_valid_s;
    logic [4:0]        wb_rd_r, wb_rd_s;
    logic [XLEN-1:0]   wb_data_r, wb_data_s;
    logic              ex_valid_r, ex_valid_s;
    logic [3:0]        ex_cause_r, ex_cause_s;
    logic              busy_r, busy_s;
    logic              timeout_s;

    // Next-state, capture and next-output logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_s       = op_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        rd_s       = rd_r;
        ack_s      = 1'b0;
        wb_valid_s = 1'b0;
        wb_rd_s    = 5'd0;
        wb_data_s  = '0;
        ex_valid_s = 1'b0;
        ex_cause_s = 4'd0;
        timeout_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (commit_valid_i && !flush_i) begin
                    op_s    = commit_op_i;
                    addr_s  = csr_addr_i;
                    wdata_s = (commit_op_i == OP_READ) ? '0 : commit_wdata_i;
                    rd_s    = commit_rd_i;
                    cnt_s   = 8'd0;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A response in the timeout cycle takes priority.
                if (csr_rvalid_i) begin
                    state_s = ST_DONE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
                // Retirement values are produced as we enter DONE so that
                // they appear on the registered outputs during DONE.
                if (state_s == ST_DONE) begin
                    ack_s = 1'b1;
                    if (timeout_s || csr_exception_i) begin
                        ex_valid_s = 1'b1;
                        ex_cause_s = CAUSE_ILLEGAL;
                    end else begin
                        wb_valid_s = (rd_r != 5'd0);
                        wb_rd_s    = rd_r;
                        wb_data_s  = csr_rdata_i;
                    end
                end else begin
                    ack_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        req_s  = (state_s == ST_REQ);
        busy_s = (state_s != ST_IDLE);
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            op_r       <= 2'd0;
            addr_r     <= 12'd0;
            wdata_r    <= '0;
            rd_r       <= 5'd0;
            req_r      <= 1'b0;
            ack_r      <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
            ex_valid_r <= 1'b0;
            ex_cause_r <= 4'd0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            op_r       <= op_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            rd_r       <= rd_s;
            req_r      <= req_s;
            ack_r      <= ack_s;
            wb_valid_r <= wb_valid_s;
            wb_rd_r    <= wb_rd_s;
            wb_data_r  <= wb_data_s;
            ex_valid_r <= ex_valid_s;
            ex_cause_r <= ex_cause_s;
            busy_r     <= busy_s;
        end
    end

    assign csr_req_o    = req_r;
    assign csr_op_o     = op_r;
    assign csr_addr_o   = addr_r;
    assign csr_wdata_o  = wdata_r;
    // The buffer entry is released on every retirement, exception or not.
    assign csr_commit_o = ack_r;
    assign commit_ack_o = ack_r;
    assign wb_valid_o   = wb_valid_r;
    assign wb_rd_o      = wb_rd_r;
    assign wb_data_o    = wb_data_r;
    assign ex_valid_o   = ex_valid_r;
    assign ex_cause_o   = ex_cause_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
module tb_csr_commit_ctrl;

    localparam int XLEN = 64;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            commit_valid_i;
    logic [1:0]      commit_op_i;
    logic [XLEN-1:0] commit_wdata_i;
    logic [4:0]      commit_rd_i;
    logic [11:0]     csr_addr_i;
    logic            csr_req_o;
    logic [1:0]      csr_op_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            csr_rvalid_i;
    logic [XLEN-1:0] csr_rdata_i;
    logic            csr_exception_i;
    logic            csr_commit_o;
    logic            commit_ack_o;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            ex_valid_o;
    logic [3:0]      ex_cause_o;
    logic            busy_o;

    always #5 clk = ~clk;

    csr_commit_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .commit_valid_i(commit_valid_i), .commit_op_i(commit_op_i),
        .commit_wdata_i(commit_wdata_i), .commit_rd_i(commit_rd_i),
        .csr_addr_i(csr_addr_i), .csr_req_o(csr_req_o), .csr_op_o(csr_op_o),
        .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_rvalid_i(csr_rvalid_i), .csr_rdata_i(csr_rdata_i),
        .csr_exception_i(csr_exception_i), .csr_commit_o(csr_commit_o),
        .commit_ack_o(commit_ack_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .ex_valid_o(ex_valid_o), .ex_cause_o(ex_cause_o),
        .busy_o(busy_o)
    );

    typedef struct {
        logic            ex;
        logic            wbv;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [156:0] all_outs();
        return {csr_req_o, csr_op_o, csr_addr_o, csr_wdata_o, csr_commit_o,
                commit_ack_o, wb_valid_o, wb_rd_o, wb_data_o, ex_valid_o,
                ex_cause_o, busy_o};
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; commit_valid_i = 1'b0;
        commit_op_i = 2'd0; commit_wdata_i = '0; commit_rd_i = 5'd0;
        csr_addr_i = 12'd0; csr_rvalid_i = 1'b0; csr_rdata_i = '0;
        csr_exception_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs() !== 157'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== 157'd0) begin
            errors++; $display("FAIL post_release_outputs: got %h expected 0", all_outs());
        end
    endtask

    // Issue one CSR op from IDLE. k = REQ cycle (1-based) in which the
    // response arrives; 0 means never.
    task automatic do_op(input string name, input logic [1:0] op,
                         input logic [11:0] addr, input logic [XLEN-1:0] wdata,
                         input logic [4:0] rd, input int k,
                         input logic [XLEN-1:0] rdata, input logic exc,
                         input logic flush_req);
        exp_t e;
        exp_t got_e;
        int exp_req;
        int req_cycles = 0;
        bit got = 1'b0;
        bit bad_fields = 1'b0;
        logic [XLEN-1:0] exp_wd;
        e.ex   = exc || (k == 0) || (k > TO);
        e.wbv  = !e.ex && (rd != 5'd0);
        e.rd   = rd;
        e.data = rdata;
        sb_q.push_back(e);
        exp_req = ((k == 0) || (k > TO)) ? TO : k;
        exp_wd  = (op == 2'd3) ? '0 : wdata;

        commit_valid_i = 1'b1; commit_op_i = op; csr_addr_i = addr;
        commit_wdata_i = wdata; commit_rd_i = rd;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            // Scramble the sources so that any late re-capture shows up.
            commit_valid_i = 1'b0; commit_op_i = ~op; csr_addr_i = ~addr;
            commit_wdata_i = ~wdata; commit_rd_i = ~rd;
            csr_rvalid_i = 1'b0; csr_exception_i = 1'b1;
            csr_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
            flush_i = 1'b0;
            if (commit_ack_o === 1'b1) begin
                got = 1'b1;
                csr_exception_i = 1'b0;
            end else if (csr_req_o === 1'b1) begin
                req_cycles++;
                if (csr_op_o !== op || csr_addr_o !== addr || csr_wdata_o !== exp_wd)
                    bad_fields = 1'b1;
                csr_exception_i = 1'b0;
                if (req_cycles == k) begin
                    csr_rvalid_i = 1'b1; csr_rdata_i = rdata; csr_exception_i = exc;
                end
                flush_i = flush_req;
            end else begin
                csr_exception_i = 1'b0;
            end
        end
        got_e = sb_q.pop_front();
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s ack_wait: got no ack expected ack", name);
        end else begin
            checks++;
            if (req_cycles != exp_req) begin
                errors++; $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cycles, exp_req);
            end
            checks++;
            if (bad_fields) begin
                errors++; $display("FAIL %s req_fields: got unstable/wrong expected op=%0d addr=%h wdata=%h", name, op, addr, exp_wd);
            end
            checks++;
            if (csr_commit_o !== 1'b1 || csr_req_o !== 1'b0) begin
                errors++; $display("FAIL %s commit_pulse: got commit=%b req=%b expected 1 0", name, csr_commit_o, csr_req_o);
            end
            checks++;
            if (ex_valid_o !== got_e.ex || wb_valid_o !== got_e.wbv) begin
                errors++; $display("FAIL %s retire_kind: got ex=%b wbv=%b expected ex=%b wbv=%b", name, ex_valid_o, wb_valid_o, got_e.ex, got_e.wbv);
            end
            checks++;
            if (got_e.ex) begin
                if (ex_cause_o !== 4'd2) begin
                    errors++; $display("FAIL %s ex_cause: got %0d expected 2", name, ex_cause_o);
                end
            end else if (wb_rd_o !== got_e.rd || wb_data_o !== got_e.data) begin
                errors++; $display("FAIL %s wb_fields: got rd=%0d data=%h expected rd=%0d data=%h", name, wb_rd_o, wb_data_o, got_e.rd, got_e.data);
            end
        end
        @(negedge clk);
        checks++;
        if (commit_ack_o !== 1'b0 || csr_commit_o !== 1'b0 || busy_o !== 1'b0 ||
            wb_valid_o !== 1'b0 || ex_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s after_done: got ack=%b commit=%b busy=%b wbv=%b ex=%b expected all 0", name, commit_ack_o, csr_commit_o, busy_o, wb_valid_o, ex_valid_o);
        end
    endtask

    task automatic test_read_immediate();
        do_op("read_imm", 2'd3, 12'h300, 64'hDEAD_BEEF, 5'd5, 1, 64'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_set_delayed();
        do_op("set_delay4", 2'd1, 12'h344, 64'h8, 5'd0, 4, 64'h77, 1'b0, 1'b0);
    endtask

    task automatic test_exception();
        do_op("exception", 2'd0, 12'hC00, 64'h1234, 5'd7, 2, 64'h55, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        do_op("timeout", 2'd2, 12'h7FF, 64'hF0, 5'd3, 0, 64'h0, 1'b0, 1'b0);
        do_op("resp_at_last", 2'd0, 12'h341, 64'h99, 5'd9, TO, 64'h1234_5678, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        bit bad = 1'b0;
        flush_i = 1'b1; commit_valid_i = 1'b1; commit_op_i = 2'd0;
        csr_addr_i = 12'h305; commit_rd_i = 5'd4; commit_wdata_i = 64'h1;
        repeat (3) begin
            @(negedge clk);
            if (csr_req_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
        end
        flush_i = 1'b0; commit_valid_i = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL flush_idle: got request/busy expected none");
        end
        do_op("flush_in_req", 2'd1, 12'h306, 64'h40, 5'd12, 3, 64'hCAFE, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_req();
        commit_valid_i = 1'b1; commit_op_i = 2'd3; csr_addr_i = 12'h301;
        commit_rd_i = 5'd6; commit_wdata_i = 64'h0;
        @(negedge clk);
        commit_valid_i = 1'b0;
        checks++;
        if (csr_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_req_entry: got req=%b expected 1", csr_req_o);
        end
        rst_ni = 1'b0;
        @(negedge clk);
        checks++;
        if (csr_req_o !== 1'b0 || commit_ack_o !== 1'b0 || csr_commit_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rst_in_req: got req=%b ack=%b commit=%b busy=%b expected 0", csr_req_o, commit_ack_o, csr_commit_o, busy_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== 157'd0) begin
            errors++; $display("FAIL rst_release: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_back_to_back();
        exp_t a;
        exp_t b;
        exp_t e;
        int acks = 0;
        int commits = 0;
        int ack_at[2] = '{0, 0};
        a.ex = 1'b0; a.wbv = 1'b1; a.rd = 5'd10; a.data = 64'h1111;
        b.ex = 1'b0; b.wbv = 1'b1; b.rd = 5'd11; b.data = 64'h2222;
        sb_q.push_back(a);
        sb_q.push_back(b);
        commit_valid_i = 1'b1; commit_op_i = 2'd3; csr_addr_i = 12'h340;
        commit_rd_i = 5'd10; commit_wdata_i = 64'h0;
        for (int n = 1; n <= 20 && acks < 2; n++) begin
            @(negedge clk);
            csr_rvalid_i = 1'b0;
            if (csr_commit_o === 1'b1) commits++;
            if (commit_ack_o === 1'b1) begin
                e = sb_q.pop_front();
                checks++;
                if (wb_valid_o !== e.wbv || wb_rd_o !== e.rd || wb_data_o !== e.data) begin
                    errors++; $display("FAIL b2b_wb%0d: got v=%b rd=%0d data=%h expected v=%b rd=%0d data=%h", acks, wb_valid_o, wb_rd_o, wb_data_o, e.wbv, e.rd, e.data);
                end
                ack_at[acks] = n;
                acks++;
                if (acks == 1) begin
                    commit_op_i = 2'd2; csr_addr_i = 12'h305;
                    commit_rd_i = 5'd11; commit_wdata_i = 64'hF0;
                end else begin
                    commit_valid_i = 1'b0;
                end
            end else if (csr_req_o === 1'b1) begin
                csr_rvalid_i = 1'b1;
                csr_rdata_i = (acks == 0) ? a.data : b.data;
            end
        end
        commit_valid_i = 1'b0;
        @(negedge clk);
        if (csr_commit_o === 1'b1) commits++;
        checks++;
        if (ack_at[0] != 2 || ack_at[1] != 5) begin
            errors++; $display("FAIL b2b_timing: got acks at %0d,%0d expected 2,5", ack_at[0], ack_at[1]);
        end
        checks++;
        if (commits != 2) begin
            errors++; $display("FAIL b2b_commits: got %0d expected 2", commits);
        end
    endtask

    initial begin
        test_reset();
        test_read_immediate();
        test_set_delayed();
        test_exception();
        test_timeout();
        test_flush();
        test_reset_in_req();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
